// File: rtl/matrix_multiply_core_3x3_bus_regs.sv
// Bus register responder for the 3x3 matrix-multiply core: a double-buffered coefficient
// bank (shadow/active) with frame-synchronous commit, plus CTRL/STATUS/ID registers.
module matrix_multiply_core_3x3_bus_regs #(
    parameter logic [19:0] BASE_ADDR = 20'h40000,
    parameter int          COEF_FRAC = 14,
    parameter logic [31:0] ID_VALUE  = 32'h4D333301
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [19:0]  sys_addr,
    input  logic [31:0]  sys_wdata,
    input  logic         sys_wen,
    input  logic         sys_ren,
    output logic [31:0]  sys_rdata,
    output logic         sys_ack,
    output logic         sys_err,
    input  logic         frame_i,
    output logic [287:0] coef_o,
    output logic         commit_o
);

    localparam logic [31:0] DIAG = 32'd1 << COEF_FRAC;

    logic [31:0] shadow_q [9];
    logic [31:0] active_q [9];
    logic        auto_q, auto_d;
    logic        pending_q, pending_d;
    logic [7:0]  count_q, count_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        commit_q, commit_d;

    logic        hit, wrEn, rdEn, doCommit;
    logic [5:0]  wordIdx;
    logic [3:0]  coefIdx;
    logic        isCoef, isCtrl, isStatus, isId, isUnmapped;
    logic [31:0] readValue;
    logic        unusedAddrBits;

    assign unusedAddrBits = ^sys_addr[1:0];

    // Address decode; the low two offset bits are ignored since all registers are words.
    always_comb begin
        hit        = (sys_addr[19:8] == BASE_ADDR[19:8]);
        wordIdx    = sys_addr[7:2];
        coefIdx    = wordIdx[3:0];
        isCoef     = (wordIdx < 6'd9);
        isCtrl     = (wordIdx == 6'd9);
        isStatus   = (wordIdx == 6'd10);
        isId       = (wordIdx == 6'd11);
        isUnmapped = (wordIdx > 6'd11);
        wrEn       = sys_wen & hit;
        rdEn       = sys_ren & hit;
        doCommit   = frame_i & (pending_q | auto_q);
    end

    // Read data always reflects the pre-write state, so a combined write+read returns the old value.
    always_comb begin
        readValue = '0;
        if (isCoef) begin
            readValue = shadow_q[coefIdx];
        end else if (isCtrl) begin
            readValue = {30'd0, auto_q, 1'b0};
        end else if (isStatus) begin
            readValue = {16'd0, count_q, 7'd0, pending_q};
        end else if (isId) begin
            readValue = ID_VALUE;
        end
    end

    always_comb begin
        ack_d     = wrEn | rdEn;
        err_d     = (wrEn | rdEn) & isUnmapped;
        rdata_d   = rdEn ? readValue : 32'd0;
        commit_d  = doCommit;
        count_d   = doCommit ? count_q + 8'd1 : count_q;
        auto_d    = (wrEn && isCtrl) ? sys_wdata[1] : auto_q;
        // A request arriving with a frame is held for the next frame, so the set wins over the clear.
        pending_d = pending_q;
        if (doCommit) begin
            pending_d = 1'b0;
        end
        if (wrEn && isCtrl && sys_wdata[0]) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 9; i++) begin
                shadow_q[i] <= (i == 0 || i == 4 || i == 8) ? DIAG : 32'd0;
                active_q[i] <= (i == 0 || i == 4 || i == 8) ? DIAG : 32'd0;
            end
            auto_q    <= 1'b0;
            pending_q <= 1'b0;
            count_q   <= 8'd0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
            commit_q  <= 1'b0;
        end else begin
            if (doCommit) begin
                for (int i = 0; i < 9; i++) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            if (wrEn && isCoef) begin
                shadow_q[coefIdx] <= sys_wdata;
            end
            auto_q    <= auto_d;
            pending_q <= pending_d;
            count_q   <= count_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            commit_q  <= commit_d;
        end
    end

    always_comb begin
        coef_o = '0;
        for (int i = 0; i < 9; i++) begin
            coef_o[i*32 +: 32] = active_q[i];
        end
    end

    assign sys_rdata = rdata_q;
    assign sys_ack   = ack_q;
    assign sys_err   = err_q;
    assign commit_o  = commit_q;

endmodule
